// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial ALU and its sequencer: control-line enums,
// the idle control word and the per-function r/s/v/ne select table.
package alu_pkg;

  typedef enum logic {
    NO_LD  = 1'b0,
    BUS_LD = 1'b1
  } ld_t;

  typedef enum logic [1:0] {
    NO_SH    = 2'd0,
    SH_LEFT  = 2'd1,
    SH_RIGHT = 2'd2
  } sh_t;

  typedef enum logic {
    SH_OE  = 1'b0,
    RES_OE = 1'b1
  } oe_t;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_ADC = 3'd1,
    FN_SUB = 3'd2,
    FN_SBC = 3'd3,
    FN_AND = 3'd4,
    FN_XOR = 3'd5,
    FN_OR  = 3'd6,
    FN_CP  = 3'd7
  } alu_fn_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD_A = 3'd1,
    ST_LD_B = 3'd2,
    ST_RES  = 3'd3,
    ST_RSP  = 3'd4
  } seq_state_t;

  // r selects XOR, s selects OR, v selects AND, none selects ADD; ne inverts B.
  typedef struct packed {
    logic r;
    logic s;
    logic v;
    logic ne;
  } fn_sel_t;

  typedef struct packed {
    logic [7:0] op;
    ld_t        la;
    ld_t        lb;
    sh_t        sh;
    oe_t        oe;
    logic       r;
    logic       s;
    logic       v;
    logic       ne;
    logic       ci;
    logic       l;
    logic       h;
  } alu_ctl_t;

  localparam alu_ctl_t ALU_IDLE_WORD = '{
    op: 8'h00, la: NO_LD, lb: NO_LD, sh: NO_SH, oe: SH_OE,
    r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
  };

  // Indexed by alu_fn_t: ADD, ADC, SUB, SBC, AND, XOR, OR, CP.
  localparam fn_sel_t FN_TABLE [8] = '{
    '{r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0},
    '{r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0},
    '{r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b1},
    '{r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b1},
    '{r: 1'b0, s: 1'b0, v: 1'b1, ne: 1'b0},
    '{r: 1'b1, s: 1'b0, v: 1'b0, ne: 1'b0},
    '{r: 1'b0, s: 1'b1, v: 1'b0, ne: 1'b0},
    '{r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b1}
  };

endpackage

// File: rtl/alu_fn_dec.sv
// Combinational decode of an ALU function into its select lines and the
// carry-in policy used by the low-nibble pass.
module alu_fn_dec
  import alu_pkg::*;
(
  input  alu_fn_t fn_i,
  input  logic    cin_i,
  output fn_sel_t sel_o,
  output logic    arith_o,
  output logic    ci_lo_o,
  output logic    is_cp_o
);

  always_comb begin
    sel_o   = FN_TABLE[fn_i];
    arith_o = 1'b0;
    ci_lo_o = 1'b0;
    is_cp_o = 1'b0;
    case (fn_i)
      FN_ADD: arith_o = 1'b1;
      FN_ADC: begin
        arith_o = 1'b1;
        ci_lo_o = cin_i;
      end
      // Subtraction is A + ~B + 1, so the low pass starts with carry set.
      FN_SUB: begin
        arith_o = 1'b1;
        ci_lo_o = 1'b1;
      end
      FN_SBC: begin
        arith_o = 1'b1;
        ci_lo_o = cin_i;
      end
      FN_CP: begin
        arith_o = 1'b1;
        ci_lo_o = 1'b1;
        is_cp_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequencer driving a nibble-serial ALU: loads A, loads B while running the low
// nibble, runs the high nibble, then holds the result/flags until taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised by the producer, is held with stable payload until
// that edge. req_ready is high only in IDLE; rsp_valid is high only in RSP.
module alu_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  alu_fn_t    req_fn,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_cin,
  output logic [7:0] alu_op,
  output ld_t        alu_la,
  output ld_t        alu_lb,
  output sh_t        alu_sh,
  output oe_t        alu_oe,
  output logic       alu_r,
  output logic       alu_s,
  output logic       alu_v,
  output logic       alu_ne,
  output logic       alu_ci,
  output logic       alu_l,
  output logic       alu_h,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_z,
  output logic       rsp_h,
  output logic       rsp_c,
  output seq_state_t dbg_state_o
);

  seq_state_t state_q, state_d;
  alu_fn_t    fn_q, fn_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic       hc_q, hc_d;
  logic [7:0] res_q, res_d;
  logic       z_q, z_d;
  logic       h_q, h_d;
  logic       c_q, c_d;

  fn_sel_t    sel;
  logic       arith;
  logic       ci_lo;
  logic       is_cp;
  alu_ctl_t   ctl;

  alu_fn_dec u_fn_dec (
    .fn_i    (fn_q),
    .cin_i   (cin_q),
    .sel_o   (sel),
    .arith_o (arith),
    .ci_lo_o (ci_lo),
    .is_cp_o (is_cp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fn_q    <= FN_ADD;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cin_q   <= 1'b0;
      hc_q    <= 1'b0;
      res_q   <= 8'h00;
      z_q     <= 1'b0;
      h_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      hc_q    <= hc_d;
      res_q   <= res_d;
      z_q     <= z_d;
      h_q     <= h_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    hc_d      = hc_q;
    res_d     = res_q;
    z_d       = z_q;
    h_d       = h_q;
    c_d       = c_q;
    ctl       = ALU_IDLE_WORD;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          fn_d    = req_fn;
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_cin;
          state_d = ST_LD_A;
        end
      end
      ST_LD_A: begin
        ctl.op  = a_q;
        ctl.la  = BUS_LD;
        state_d = ST_LD_B;
      end
      // Low-nibble pass: B is on the bus while the ALU adds the low halves.
      ST_LD_B: begin
        ctl.op  = b_q;
        ctl.lb  = BUS_LD;
        ctl.r   = sel.r;
        ctl.s   = sel.s;
        ctl.v   = sel.v;
        ctl.ne  = sel.ne;
        ctl.ci  = ci_lo;
        ctl.l   = 1'b1;
        hc_d    = arith & alu_carry;
        state_d = ST_RES;
      end
      // High-nibble pass chains the low-nibble carry; CP keeps A as its result.
      ST_RES: begin
        ctl.oe  = RES_OE;
        ctl.r   = sel.r;
        ctl.s   = sel.s;
        ctl.v   = sel.v;
        ctl.ne  = sel.ne;
        ctl.ci  = arith & hc_q;
        ctl.h   = 1'b1;
        res_d   = is_cp ? a_q : alu_result;
        z_d     = alu_zero;
        h_d     = hc_q;
        c_d     = arith & alu_carry;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_op      = ctl.op;
  assign alu_la      = ctl.la;
  assign alu_lb      = ctl.lb;
  assign alu_sh      = ctl.sh;
  assign alu_oe      = ctl.oe;
  assign alu_r       = ctl.r;
  assign alu_s       = ctl.s;
  assign alu_v       = ctl.v;
  assign alu_ne      = ctl.ne;
  assign alu_ci      = ctl.ci;
  assign alu_l       = ctl.l;
  assign alu_h       = ctl.h;

  assign rsp_result  = res_q;
  assign rsp_z       = z_q;
  assign rsp_h       = h_q;
  assign rsp_c       = c_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 Port reset_n, input, 1, asynchronous active-low reset.
REQ-003 Port req_valid, input, 1, operation request present.
REQ-004 Port req_ready, output, 1, sequencer accepts a request this cycle.
REQ-005 Port req_fn, input, alu_fn_t (3), operation: ADD, ADC, SUB, SBC, AND, XOR, OR, CP.
REQ-006 Port req_a / req_b, input, 8 each, operands; req_cin, input, 1, carry-in for ADC/SBC.
REQ-007 Port alu_op, output, 8, ALU operand bus.
REQ-008 Port alu_la / alu_lb, output, ld_t, operand-latch load selects (NO_LD, BUS_LD).
REQ-009 Port alu_sh, output, sh_t, shifter select; alu_oe, output, oe_t, output-enable select (SH_OE, RES_OE).
REQ-010 Port alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h, outputs, 1 each, ALU function, carry-in and nibble-select lines.
REQ-011 Port alu_result, input, 8; alu_zero, input, 1; alu_carry, input, 1; ALU outputs.
REQ-012 Port rsp_valid, output, 1, response held; rsp_ready, input, 1, consumer takes response.
REQ-013 Port rsp_result, output, 8; rsp_z, rsp_h, rsp_c, output, 1 each, result and Z/H/C flags.

Function
REQ-014 FSM states SHALL be IDLE, LD_A, LD_B, RES, RSP; req_ready = 1 only in IDLE.
REQ-015 IDLE: req_valid & req_ready SHALL register fn, a, b, cin and move to LD_A; otherwise stay.
REQ-016 Every non-RSP cycle outside LD_A/LD_B/RES SHALL drive the idle word: op=0x00, la=lb=NO_LD, sh=NO_SH, oe=SH_OE, r=s=v=ne=ci=l=h=0.
REQ-017 LD_A (1 cycle): op=a, sh=NO_SH, oe=SH_OE, la=BUS_LD, lb=NO_LD, function bits 0; next LD_B.
REQ-018 LD_B (1 cycle): op=b, sh=NO_SH, oe=SH_OE, la=NO_LD, lb=BUS_LD, r/s/v/ne from function table for fn, ci = cin for ADC/SBC, 1 for SUB/CP, 0 otherwise, l=1, h=0; next RES.
REQ-019 LD_B SHALL register alu_carry as half-carry (low-nibble carry); forced 0 for AND/XOR/OR.
REQ-020 RES (1 cycle): la=lb=NO_LD, oe=RES_OE, same r/s/v/ne, ci = registered half-carry for arithmetic fns else 0, l=0, h=1; next RSP.
REQ-021 RES SHALL register alu_result, alu_zero, alu_carry; carry forced 0 for AND/XOR/OR.
REQ-022 CP SHALL report flags of SUB but rsp_result = registered a.
REQ-023 RSP: rsp_valid=1, outputs stable, idle word on ALU lines; rsp_valid & rsp_ready returns to IDLE next cycle.
REQ-024 Latency: accept at cycle T -> rsp_valid first high at T+4; back-to-back throughput one op per 5 cycles when rsp_ready=1.
REQ-025 rsp_valid SHALL hold indefinitely while rsp_ready=0; no new request accepted meanwhile.
REQ-026 req_* changes after acceptance SHALL have no effect on the op in flight.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_result=0x00, rsp_z=rsp_h=rsp_c=0, ALU lines = idle word, including mid-operation; aborted op yields no response.
REQ-028 First acceptance possible on the first rising edge after reset_n deasserts.

Structure
REQ-029 Package alu_pkg SHALL hold ld_t, sh_t, oe_t, alu_fn_t, the idle-word constant and the per-fn r/s/v/ne function table, shared with the ALU and its benches.
REQ-030 One sub-module alu_fn_dec (combinational fn -> r/s/v/ne/ci-policy decode) is natural; FSM and capture registers stay in alu_seq.

Verification
REQ-031 XOR a=0x5A b=0xFF -> at T+4 rsp_result=0xA5, z=0, h=0, c=0; LD_B/RES lines r=1,s=0,v=0,ne=0,ci=0.
REQ-032 XOR a=0x3C b=0x3C -> rsp_result=0x00, z=1, c=0.
REQ-033 ADD a=0x0F b=0x01 -> rsp_result=0x10, z=0, h=1, c=0; RES cycle ci=1.
REQ-034 ADD a=0xFF b=0x01 -> rsp_result=0x00, z=1, h=1, c=1.
REQ-035 rsp_ready=0 for 10 cycles after response -> rsp_valid and payload stable, req_ready=0 throughout; second op accepted cycle after handshake.
REQ-036 reset_n pulsed low during LD_B -> same cycle idle word, req_ready=1, rsp_valid=0; no response ever issued for aborted op.
